// File: rtl/ahb3lite_interconnect_master_port_err_if.sv
// AHB3-Lite master-layer bus between one master and its port on the multi-layer switch.
// The switch port is the AHB slave on this bus, so it uses the slave modport.
interface ahb3lite_interconnect_master_port_err_if #(
    parameter int unsigned HADDR_SIZE = 32,
    parameter int unsigned HDATA_SIZE = 32
);
    logic                  HSEL;
    logic [HADDR_SIZE-1:0] HADDR;
    logic [HDATA_SIZE-1:0] HWDATA;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [3:0]            HPROT;
    logic [1:0]            HTRANS;
    logic                  HMASTLOCK;
    logic                  HREADY;
    logic [HDATA_SIZE-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRESP;

    modport master (
        output HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HWDATA, HWRITE, HSIZE, HBURST, HPROT, HTRANS, HMASTLOCK, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/ahb3lite_interconnect_master_port_err.sv
// Master-side port of the AHB3-Lite multi-layer switch: decodes onto the slave ports, holds
// requests while they arbitrate, and answers unmapped or timed-out accesses with an AHB ERROR.
module ahb3lite_interconnect_master_port_err #(
    parameter int unsigned       HADDR_SIZE   = 32,
    parameter int unsigned       HDATA_SIZE   = 32,
    parameter int unsigned       MASTERS      = 3,
    parameter int unsigned       SLAVES       = 8,
    parameter logic [SLAVES-1:0] SLAVE_MASK   = {SLAVES{1'b1}},
    parameter bit                ERR_UNMAPPED = 1'b1,
    parameter int unsigned       TIMEOUT      = 0
) (
    input  logic                  HCLK,
    input  logic                  HRESETn,
    input  logic [2:0]            mst_priority,
    ahb3lite_interconnect_master_port_err_if.slave mst,
    input  logic [HADDR_SIZE-1:0] slvHADDRmask [SLAVES],
    input  logic [HADDR_SIZE-1:0] slvHADDRbase [SLAVES],
    output logic [SLAVES-1:0]     slvHSEL,
    output logic [HADDR_SIZE-1:0] slvHADDR,
    output logic [HDATA_SIZE-1:0] slvHWDATA,
    output logic                  slvHWRITE,
    output logic [2:0]            slvHSIZE,
    output logic [2:0]            slvHBURST,
    output logic [3:0]            slvHPROT,
    output logic [1:0]            slvHTRANS,
    output logic                  slvHMASTLOCK,
    input  logic [HDATA_SIZE-1:0] slvHRDATA [SLAVES],
    input  logic [SLAVES-1:0]     slvHREADY,
    input  logic [SLAVES-1:0]     slvHRESP,
    output logic                  slvHREADYOUT,
    output logic [2:0]            slvpriority,
    input  logic [SLAVES-1:0]     master_granted,
    output logic                  can_switch,
    output logic                  err_event
);
    localparam int unsigned SelW       = (SLAVES > 1) ? $clog2(SLAVES) : 1;
    localparam logic [7:0]  TimeoutCnt = 8'(TIMEOUT);

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StPending = 3'd1;
    localparam logic [2:0] StGranted = 3'd2;
    localparam logic [2:0] StErr1    = 3'd3;
    localparam logic [2:0] StErr2    = 3'd4;

    localparam logic [1:0] TransIdle   = 2'b00;
    localparam logic [1:0] TransNonseq = 2'b10;
    localparam logic [1:0] TransSeq    = 2'b11;
    localparam logic [2:0] BurstSingle = 3'd0;
    localparam logic [2:0] BurstIncr   = 3'd1;

    if (SLAVES < 1 || SLAVES > 32 || MASTERS < 1 || TIMEOUT > 255) begin : g_param_check
        $error("ahb3lite_interconnect_master_port_err: parameter out of range");
    end

    logic [2:0]            state_q, state_d;
    logic [SelW-1:0]       req_sel_q;
    logic [HADDR_SIZE-1:0] req_addr_q;
    logic                  req_write_q;
    logic [2:0]            req_size_q;
    logic [2:0]            req_burst_q;
    logic [3:0]            req_prot_q;
    logic [1:0]            req_trans_q;
    logic                  req_lock_q;
    logic [2:0]            req_prio_q;
    logic [7:0]            wait_cnt_q, wait_cnt_d;
    logic [3:0]            burst_cnt_q, burst_cnt_d;

    logic [SLAVES-1:0] hit;
    logic [SelW-1:0]   sel_idx;
    logic              mapped, valid, pending, accept, req_now, timeout_hit;
    logic [2:0]        decode_st;
    logic [3:0]        burst_load;

    // Lowest-index hit wins, so scan from the top down.
    always_comb begin
        hit = '0;
        for (int s = 0; s < int'(SLAVES); s++) begin
            hit[s] = SLAVE_MASK[s] &
                     ((mst.HADDR & slvHADDRmask[s]) == (slvHADDRbase[s] & slvHADDRmask[s]));
        end
        sel_idx = '0;
        for (int s = int'(SLAVES) - 1; s >= 0; s--) begin
            if (hit[s]) sel_idx = SelW'(s);
        end
    end

    assign mapped  = |hit;
    assign valid   = mst.HSEL & mst.HTRANS[1];
    assign pending = (state_q == StPending);
    assign accept  = mst.HREADY &
                     ((state_q == StIdle) || (state_q == StGranted) || (state_q == StErr2));
    assign req_now = accept & valid & mapped;

    // A locked transfer is never aborted by the grant-wait limit.
    assign timeout_hit = (TIMEOUT != 0) && pending && !req_lock_q && (wait_cnt_q == TimeoutCnt);

    always_comb begin
        decode_st = StIdle;
        if (valid) begin
            if (mapped)            decode_st = master_granted[sel_idx] ? StGranted : StPending;
            else if (ERR_UNMAPPED) decode_st = StErr1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StGranted, StErr2: if (mst.HREADY) state_d = decode_st;
            StPending: begin
                if (timeout_hit) begin
                    state_d = StErr1;
                end else if (master_granted[req_sel_q] & slvHREADY[req_sel_q]) begin
                    state_d = StGranted;
                end
            end
            StErr1:  state_d = StErr2;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (state_d == StPending) begin
            wait_cnt_d = !pending ? 8'd1 : (wait_cnt_q == 8'hFF) ? wait_cnt_q : wait_cnt_q + 8'd1;
        end else begin
            wait_cnt_d = '0;
        end
    end

    // Beats remaining after the current SEQ; the final beat of a fixed burst sees zero.
    always_comb begin
        case (mst.HBURST)
            3'd2, 3'd3: burst_load = 4'd2;
            3'd4, 3'd5: burst_load = 4'd6;
            3'd6, 3'd7: burst_load = 4'd14;
            default:    burst_load = 4'd0;
        endcase
        burst_cnt_d = burst_cnt_q;
        if (accept && mst.HSEL) begin
            if (mst.HTRANS == TransNonseq) begin
                burst_cnt_d = burst_load;
            end else if (mst.HTRANS == TransSeq && burst_cnt_q != 4'd0) begin
                burst_cnt_d = burst_cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StIdle;
            req_sel_q   <= '0;
            req_addr_q  <= '0;
            req_write_q <= 1'b0;
            req_size_q  <= '0;
            req_burst_q <= '0;
            req_prot_q  <= '0;
            req_trans_q <= TransIdle;
            req_lock_q  <= 1'b0;
            req_prio_q  <= '0;
            wait_cnt_q  <= '0;
            burst_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            if (accept) begin
                req_sel_q   <= sel_idx;
                req_addr_q  <= mst.HADDR;
                req_write_q <= mst.HWRITE;
                req_size_q  <= mst.HSIZE;
                req_burst_q <= mst.HBURST;
                req_prot_q  <= mst.HPROT;
                req_trans_q <= mst.HTRANS;
                req_lock_q  <= mst.HMASTLOCK;
                req_prio_q  <= mst_priority;
            end
        end
    end

    // Slave-side request: live from the master unless a held request is being replayed.
    always_comb begin
        slvHSEL   = '0;
        slvHWDATA = mst.HWDATA;
        if (pending) begin
            slvHADDR     = req_addr_q;
            slvHWRITE    = req_write_q;
            slvHSIZE     = req_size_q;
            slvHBURST    = req_burst_q;
            slvHPROT     = req_prot_q;
            slvHMASTLOCK = req_lock_q;
            slvHTRANS    = (req_trans_q == TransSeq && req_burst_q == BurstIncr) ? TransNonseq
                                                                                   : req_trans_q;
            slvHREADYOUT = slvHREADY[req_sel_q];
            slvpriority  = req_prio_q;
            if (!timeout_hit) slvHSEL[req_sel_q] = 1'b1;
        end else begin
            slvHADDR     = mst.HADDR;
            slvHWRITE    = mst.HWRITE;
            slvHSIZE     = mst.HSIZE;
            slvHBURST    = mst.HBURST;
            slvHPROT     = mst.HPROT;
            slvHMASTLOCK = mst.HMASTLOCK;
            slvHTRANS    = mst.HTRANS;
            slvHREADYOUT = mst.HREADY;
            slvpriority  = mst_priority;
            if (req_now) slvHSEL[sel_idx] = 1'b1;
        end
        if (slvHSEL == '0) slvHTRANS = TransIdle;
    end

    always_comb begin
        mst.HREADYOUT = 1'b1;
        mst.HRESP     = 1'b0;
        mst.HRDATA    = '0;
        case (state_q)
            StPending: mst.HREADYOUT = 1'b0;
            StGranted: begin
                mst.HREADYOUT = slvHREADY[req_sel_q];
                mst.HRESP     = slvHRESP[req_sel_q];
                mst.HRDATA    = slvHRDATA[req_sel_q];
            end
            StErr1: begin
                mst.HREADYOUT = 1'b0;
                mst.HRESP     = 1'b1;
            end
            StErr2:  mst.HRESP = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        can_switch = 1'b0;
        case (state_q)
            StIdle:         can_switch = ~|master_granted;
            StPending:      can_switch = ~master_granted[req_sel_q];
            StErr1, StErr2: can_switch = 1'b1;
            StGranted: begin
                can_switch = mst.HREADY & ~mst.HMASTLOCK &
                             (~mst.HSEL || mst.HTRANS == TransIdle ||
                              (mst.HTRANS == TransNonseq && mst.HBURST == BurstSingle) ||
                              (mst.HTRANS == TransSeq && burst_cnt_q == 4'd0 &&
                               mst.HBURST != BurstSingle && mst.HBURST != BurstIncr));
            end
            default: ;
        endcase
    end

    assign err_event = (state_q == StErr1);
endmodule

// File: tb/tb_ahb3lite_interconnect_master_port_err.sv
// Directed bench for the error-capable master port: decode, hold, unmapped/timeout ERROR,
// burst-aware can_switch and asynchronous reset recovery.
module tb_ahb3lite_interconnect_master_port_err;
    localparam int unsigned Slaves = 8;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b1;
    logic [2:0]  mst_priority;
    logic [31:0] mask  [Slaves];
    logic [31:0] base  [Slaves];
    logic [31:0] rdata [Slaves];
    logic [7:0]  slv_hsel, slv_ready, slv_resp, granted;
    logic [31:0] slv_haddr, slv_hwdata;
    logic        slv_hwrite, slv_hmastlock, slv_hreadyout, can_switch, err_event;
    logic [2:0]  slv_hsize, slv_hburst, slv_prio;
    logic [3:0]  slv_hprot;
    logic [1:0]  slv_htrans;
    int          errors = 0;
    int          checks = 0;

    ahb3lite_interconnect_master_port_err_if #(.HADDR_SIZE(32), .HDATA_SIZE(32)) bus ();
    assign bus.HREADY = bus.HREADYOUT;

    always #5 HCLK = ~HCLK;

    ahb3lite_interconnect_master_port_err #(
        .SLAVES       (Slaves),
        .ERR_UNMAPPED (1'b1),
        .TIMEOUT      (4)
    ) dut (
        .HCLK           (HCLK),
        .HRESETn        (HRESETn),
        .mst_priority   (mst_priority),
        .mst            (bus),
        .slvHADDRmask   (mask),
        .slvHADDRbase   (base),
        .slvHSEL        (slv_hsel),
        .slvHADDR       (slv_haddr),
        .slvHWDATA      (slv_hwdata),
        .slvHWRITE      (slv_hwrite),
        .slvHSIZE       (slv_hsize),
        .slvHBURST      (slv_hburst),
        .slvHPROT       (slv_hprot),
        .slvHTRANS      (slv_htrans),
        .slvHMASTLOCK   (slv_hmastlock),
        .slvHRDATA      (rdata),
        .slvHREADY      (slv_ready),
        .slvHRESP       (slv_resp),
        .slvHREADYOUT   (slv_hreadyout),
        .slvpriority    (slv_prio),
        .master_granted (granted),
        .can_switch     (can_switch),
        .err_event      (err_event)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic sel, input logic [31:0] addr, input logic [1:0] trans,
                       input logic [2:0] burst, input logic write, input logic lock);
        bus.HSEL      = sel;
        bus.HADDR     = addr;
        bus.HTRANS    = trans;
        bus.HBURST    = burst;
        bus.HWRITE    = write;
        bus.HMASTLOCK = lock;
        bus.HSIZE     = 3'd2;
        bus.HPROT     = 4'b0011;
        bus.HWDATA    = addr ^ 32'h5A5A_5A5A;
        #1;
    endtask

    task automatic idle();
        req(1'b0, 32'h0, 2'b00, 3'd0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge HCLK);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Slave s decodes 0x0800_0000 * s with a 128 MiB window; 0x4000_0000 and up is unmapped.
        for (int s = 0; s < int'(Slaves); s++) begin
            mask[s]  = 32'hF800_0000;
            base[s]  = 32'h0800_0000 * s;
            rdata[s] = 32'hD0D0_0000 + s;
        end
        slv_ready    = 8'hFF;
        slv_resp     = 8'h00;
        granted      = 8'h00;
        mst_priority = 3'd5;
        idle();
        HRESETn = 1'b0;
        #2;
        chk("rst_hreadyout", bus.HREADYOUT, 1);
        chk("rst_hresp", bus.HRESP, 0);
        chk("rst_slvhsel", slv_hsel, 0);
        chk("rst_slvhtrans", slv_htrans, 0);
        chk("rst_err_event", err_event, 0);
        chk("rst_can_switch", can_switch, 1);
        @(posedge HCLK);
        #2;
        HRESETn = 1'b1;
        tick();

        // T1: single read to slave 2, granted at once.
        granted = 8'h04;
        req(1'b1, 32'h1000_0004, 2'b10, 3'd0, 1'b0, 1'b0);
        chk("t1_slvhsel", slv_hsel, 32'h04);
        chk("t1_slvhaddr", slv_haddr, 32'h1000_0004);
        chk("t1_slvhtrans", slv_htrans, 2);
        chk("t1_can_switch_granted", can_switch, 0);
        tick();
        granted = 8'h00;
        idle();
        chk("t1_hreadyout", bus.HREADYOUT, 1);
        chk("t1_hresp", bus.HRESP, 0);
        chk("t1_hrdata", bus.HRDATA, 32'hD0D0_0002);
        chk("t1_can_switch_done", can_switch, 1);
        tick();

        // T2: write to slave 1, grant withheld, priority held from the address phase.
        req(1'b1, 32'h0800_0010, 2'b10, 3'd0, 1'b1, 1'b0);
        chk("t2_slvhsel_req", slv_hsel, 32'h02);
        tick();
        mst_priority = 3'd1;
        idle();
        for (int i = 0; i < 3; i++) begin
            chk("t2_hreadyout_wait", bus.HREADYOUT, 0);
            chk("t2_slvhaddr_held", slv_haddr, 32'h0800_0010);
            chk("t2_slvhsel_held", slv_hsel, 32'h02);
            if (i == 0) begin
                chk("t2_slvhwrite_held", slv_hwrite, 1);
                chk("t2_slvprio_held", slv_prio, 5);
                chk("t2_can_switch_nogrant", can_switch, 1);
            end
            if (i == 2) granted = 8'h02;
            tick();
        end
        granted = 8'h00;
        mst_priority = 3'd5;
        chk("t2_hreadyout_done", bus.HREADYOUT, 1);
        chk("t2_hresp_okay", bus.HRESP, 0);
        tick();

        // T3: write to unmapped address gives the two-cycle ERROR.
        req(1'b1, 32'hF000_0000, 2'b10, 3'd0, 1'b1, 1'b0);
        chk("t3_slvhsel_none", slv_hsel, 0);
        tick();
        idle();
        chk("t3_err1_hreadyout", bus.HREADYOUT, 0);
        chk("t3_err1_hresp", bus.HRESP, 1);
        chk("t3_err1_event", err_event, 1);
        tick();
        chk("t3_err2_hreadyout", bus.HREADYOUT, 1);
        chk("t3_err2_hresp", bus.HRESP, 1);
        chk("t3_err2_event", err_event, 0);
        tick();
        chk("t3_idle_hresp", bus.HRESP, 0);

        // T4: slave 4 never grants; ERROR four cycles after entering the wait.
        req(1'b1, 32'h2000_0000, 2'b10, 3'd0, 1'b0, 1'b0);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("t4_wait_hreadyout", bus.HREADYOUT, 0);
            chk("t4_wait_event", err_event, 0);
            chk("t4_wait_slvhsel", slv_hsel, (i == 3) ? 32'h00 : 32'h10);
            tick();
        end
        chk("t4_err1_hreadyout", bus.HREADYOUT, 0);
        chk("t4_err1_hresp", bus.HRESP, 1);
        chk("t4_err1_event", err_event, 1);
        chk("t4_err1_slvhsel", slv_hsel, 0);
        tick();
        chk("t4_err2_hreadyout", bus.HREADYOUT, 1);
        chk("t4_err2_hresp", bus.HRESP, 1);
        tick();

        // T5a: INCR8 to slave 3 may only be switched away on its last beat.
        granted = 8'h08;
        for (int b = 1; b <= 8; b++) begin
            req(1'b1, 32'h1800_0000 + 32'(4 * (b - 1)), (b == 1) ? 2'b10 : 2'b11, 3'd5, 1'b0,
                1'b0);
            chk($sformatf("t5_incr8_can_switch_beat%0d", b), can_switch, (b == 8) ? 1 : 0);
            tick();
        end
        idle();
        chk("t5_incr8_tail_can_switch", can_switch, 1);
        chk("t5_incr8_tail_hreadyout", bus.HREADYOUT, 1);
        tick();

        // T5b: locked INCR keeps the slave port throughout.
        for (int b = 1; b <= 4; b++) begin
            req(1'b1, 32'h1800_0040 + 32'(4 * (b - 1)), (b == 1) ? 2'b10 : 2'b11, 3'd1, 1'b0,
                1'b1);
            chk($sformatf("t5_lock_can_switch_beat%0d", b), can_switch, 0);
            if (b == 2) chk("t5_lock_slvhmastlock", slv_hmastlock, 1);
            tick();
        end
        idle();
        chk("t5_lock_release_can_switch", can_switch, 1);
        tick();

        // Replayed SEQ of an INCR burst goes out as NONSEQ.
        req(1'b1, 32'h1800_0100, 2'b10, 3'd1, 1'b0, 1'b0);
        tick();
        granted = 8'h00;
        req(1'b1, 32'h1800_0104, 2'b11, 3'd1, 1'b0, 1'b0);
        chk("replay_direct_slvhtrans", slv_htrans, 3);
        tick();
        idle();
        chk("replay_slvhtrans_nonseq", slv_htrans, 2);
        chk("replay_slvhaddr", slv_haddr, 32'h1800_0104);
        chk("replay_hreadyout", bus.HREADYOUT, 0);
        granted = 8'h08;
        tick();
        granted = 8'h00;
        chk("replay_done_hreadyout", bus.HREADYOUT, 1);
        tick();

        // T6a: reset while waiting for a grant.
        req(1'b1, 32'h0800_0020, 2'b10, 3'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_pending_hreadyout", bus.HREADYOUT, 0);
        HRESETn = 1'b0;
        #1;
        chk("t6_rstpend_hreadyout", bus.HREADYOUT, 1);
        chk("t6_rstpend_slvhsel", slv_hsel, 0);
        chk("t6_rstpend_hresp", bus.HRESP, 0);
        tick();
        HRESETn = 1'b1;
        tick();
        granted = 8'h04;
        req(1'b1, 32'h1000_0004, 2'b10, 3'd0, 1'b0, 1'b0);
        chk("t6_after_slvhsel", slv_hsel, 32'h04);
        tick();
        granted = 8'h00;
        idle();
        chk("t6_after_hrdata", bus.HRDATA, 32'hD0D0_0002);
        chk("t6_after_hreadyout", bus.HREADYOUT, 1);
        tick();

        // T6b: reset during the first ERROR cycle; no ERROR follows.
        req(1'b1, 32'hF000_0000, 2'b10, 3'd0, 1'b0, 1'b0);
        tick();
        idle();
        chk("t6_err1_event", err_event, 1);
        HRESETn = 1'b0;
        #1;
        chk("t6_rsterr_event", err_event, 0);
        chk("t6_rsterr_hresp", bus.HRESP, 0);
        chk("t6_rsterr_hreadyout", bus.HREADYOUT, 1);
        HRESETn = 1'b1;
        tick();
        chk("t6_post_hresp", bus.HRESP, 0);
        chk("t6_post_event", err_event, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
